// File: rtl/axis_in_pkg.sv
// Shared types for the AXI-Stream input stage: control FSM state encoding and
// a helper that sizes FIFO pointers from the configured depth.
package axis_in_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Depth of 2 still needs a 1-bit pointer, so clamp at one bit.
  function automatic int unsigned ptrWidth(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with registered occupancy; full/empty come straight from
// flops. The head output keeps the last popped word while the FIFO is empty.
module axis_sync_fifo
  import axis_in_pkg::*;
#(
  parameter int unsigned pWIDTH = 33,
  parameter int unsigned pDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [pWIDTH-1:0] wdata_i,
  input  logic              pop_i,
  output logic [pWIDTH-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PW = ptrWidth(pDEPTH);
  localparam int unsigned CW = PW + 1;

  logic [pWIDTH-1:0] mem_q [pDEPTH];
  logic [PW-1:0]     wrPtr_q, wrPtr_d;
  logic [PW-1:0]     rdPtr_q, rdPtr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [pWIDTH-1:0] hold_q, hold_d;
  logic              doPush, doPop;

  assign full_o  = (count_q == CW'(pDEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;
  assign head_o  = empty_o ? hold_q : mem_q[rdPtr_q];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    hold_d  = hold_q;
    if (doPush) wrPtr_d = wrPtr_q + PW'(1);
    if (doPop) begin
      rdPtr_d = rdPtr_q + PW'(1);
      hold_d  = mem_q[rdPtr_q];
    end
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: nothing reads it until a push has marked it valid.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      hold_q  <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: rtl/axis_in_fifo.sv
// AXI-Stream input stage: frame FSM, sample counter and FIFO feeding the FIR.
// Optional frame-length checking is enabled with AXIS_IN_FIFO_LEN_CHECK_EN.
module axis_in_fifo
  import axis_in_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pDEPTH      = 4,
  parameter int unsigned pCNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ap_start,
  input  logic                   tvalid,
  input  logic [pDATA_WIDTH-1:0] tdata,
  input  logic                   tlast,
  output logic                   tready,
  output logic [pDATA_WIDTH-1:0] strm_data,
  output logic                   strm_valid,
  output logic                   strm_last,
  input  logic                   fir_ready,
  output logic                   axis_finish,
`ifdef AXIS_IN_FIFO_LEN_CHECK_EN
  input  logic [pCNT_WIDTH-1:0]  data_length,
  output logic                   len_err,
`endif
  output logic [pCNT_WIDTH-1:0]  sample_cnt
);

  state_e                  state_q, state_d;
  logic [pCNT_WIDTH-1:0]   sampleCnt_q, sampleCnt_d;
  logic                    finish_q, finish_d;
  logic [pDATA_WIDTH:0]    head;
  logic                    full, empty;
  logic                    push, pop;

  axis_sync_fifo #(
    .pWIDTH (pDATA_WIDTH + 1),
    .pDEPTH (pDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i ({tlast, tdata}),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // tready derives only from flops, breaking the combinational ready chain.
  assign tready      = (state_q == RUN) & ~full;
  assign push        = tvalid & tready;
  assign strm_valid  = ~empty;
  assign pop         = strm_valid & fir_ready;
  assign strm_data   = head[pDATA_WIDTH-1:0];
  assign strm_last   = head[pDATA_WIDTH];
  assign axis_finish = finish_q;
  assign sample_cnt  = sampleCnt_q;

  always_comb begin
    state_d     = state_q;
    finish_d    = 1'b0;
    sampleCnt_d = sampleCnt_q;
    case (state_q)
      IDLE: begin
        if (ap_start) begin
          state_d     = RUN;
          sampleCnt_d = '0;
        end
      end
      RUN: begin
        if (push && tlast) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && strm_last) begin
          state_d  = IDLE;
          finish_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (push && (sampleCnt_q != '1)) sampleCnt_d = sampleCnt_q + pCNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sampleCnt_q <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sampleCnt_q <= sampleCnt_d;
      finish_q    <= finish_d;
    end
  end

`ifdef AXIS_IN_FIFO_LEN_CHECK_EN
  logic                  lenErr_q, lenErr_d;
  logic [pCNT_WIDTH-1:0] cntPlusOne;

  assign cntPlusOne = sampleCnt_q + pCNT_WIDTH'(1);
  assign len_err    = lenErr_q;

  // Flags both an early tlast and a missing tlast at the expected length.
  always_comb begin
    lenErr_d = lenErr_q;
    if (state_q == IDLE && ap_start) lenErr_d = 1'b0;
    if (push && ((tlast && cntPlusOne != data_length) ||
                 (!tlast && cntPlusOne == data_length))) lenErr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lenErr_q <= 1'b0;
    else        lenErr_q <= lenErr_d;
  end
`endif

endmodule

// File: doc/axis_in_fifo.md
# axis_in_fifo

Parametrised AXI-Stream input stage between the testbench/host stream and the FIR dataflow core. Accepts beats on an AXI-Stream slave port into a small synchronous FIFO, which decouples host back-pressure from FIR back-pressure and removes the one-beat coupling of combinational `tready`. Tracks the frame boundary via `tlast`, counts accepted samples, and pulses `axis_finish` only after the last sample of the frame has been handed to the FIR.

## Interface
Parameters:
- `pDATA_WIDTH`, 32, stream data width
- `pDEPTH`, 4, FIFO depth in words; power of two, ≥ 2
- `pCNT_WIDTH`, 16, width of the sample counter (and `data_length` when enabled)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `ap_start`  in  1  single-cycle frame start request
- `tvalid`  in  1  host beat valid
- `tdata`  in  pDATA_WIDTH  host beat data
- `tlast`  in  1  last beat of frame
- `tready`  out  1  ready to accept a host beat
- `strm_data`  out  pDATA_WIDTH  FIFO head data to FIR
- `strm_valid`  out  1  FIFO head valid
- `strm_last`  out  1  FIFO head is the frame's last sample
- `fir_ready`  in  1  FIR accepts head this cycle
- `axis_finish`  out  1  one-cycle pulse: last sample consumed by FIR
- `sample_cnt`  out  pCNT_WIDTH  beats accepted in current frame
- `data_length`  in  pCNT_WIDTH  expected frame length (only with `AXIS_IN_FIFO_LEN_CHECK_EN`)
- `len_err`  out  1  sticky frame-length mismatch (only with `AXIS_IN_FIFO_LEN_CHECK_EN`)

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: `tready`=0. `ap_start`=1 → RUN; clears `sample_cnt` and `len_err`; FIFO must already be empty.
- RUN: `tready` = ~full. Push on `tvalid & tready`; pushed word stores `{tlast, tdata}`. Push with `tlast`=1 → DRAIN.
- DRAIN: `tready`=0. When the pop of the word with `strm_last`=1 occurs → IDLE, `axis_finish` pulses.
- `ap_start` in RUN/DRAIN is ignored.
- Output side is state-independent: `strm_valid` = ~empty; `strm_data`/`strm_last` = head word; pop on `strm_valid & fir_ready`.
- Push and pop in the same cycle: both take effect, occupancy unchanged. Because `tready` = ~full, no push occurs when full, even with a simultaneous pop (registered-full design, no bypass).
- Pointers are log2(pDEPTH) bits and wrap naturally; occupancy counter is log2(pDEPTH)+1 bits; full = occupancy==pDEPTH.
- `sample_cnt` increments per accepted beat and saturates at all-ones.
- `strm_data` holds the last head value when empty; consumers must qualify with `strm_valid`.

## Timing
- Reset values: `tready`=0, `strm_valid`=0, `strm_last`=0, `strm_data`=0, `axis_finish`=0, `sample_cnt`=0, `len_err`=0, state IDLE, FIFO empty.
- `tready` is registered state/occupancy only; it has no combinational path from `tvalid` or `fir_ready`.
- Latency: a beat accepted at edge N is presented on `strm_valid` in the cycle after edge N; 1 cycle from the input to the FIR.
- `tready` rises the cycle after the edge that samples `ap_start`.
- `axis_finish` is high for exactly the cycle after the edge that pops the last word.
- Reset mid-frame: FIFO content discarded, all outputs go to reset values immediately.

## Configuration
- `AXIS_IN_FIFO_LEN_CHECK_EN` defined: adds the `data_length` and `len_err` ports. On the `tlast` push, `len_err` is set if `sample_cnt+1 != data_length`. It is also set if a push occurs without `tlast` when `sample_cnt+1 == data_length`. It stays set until the next `ap_start`.
- Not defined: ports absent, no length-check logic; all other behaviour is identical.

## Structure
- `axis_in_pkg`: state enum (IDLE/RUN/DRAIN) and a function computing the pointer width from `pDEPTH`.
- Sub-module `axis_sync_fifo`: width pDATA_WIDTH+1, depth pDEPTH, push/pop/full/empty/head. FSM, counter and length check stay in the top level.

## Test plan
- Reset, then `ap_start` with 11 beats (1..11, `tlast` on 11) and `fir_ready`=1 → FIR receives 1..11 in order with `strm_last` only on 11. `sample_cnt`=11. `axis_finish` pulses once, one cycle after the pop of 11.
- `fir_ready`=0 while 6 beats are offered, pDEPTH=4 → `tready` drops after 4 accepts. Raising `fir_ready` delivers all 6 beats with no loss or duplication.
- Random `tvalid`/`fir_ready` toggling over 100 beats → output sequence equals input sequence. Occupancy never exceeds 4. No push while full.
- Beats with `tvalid`=1 before `ap_start` and during DRAIN → not accepted (`tready`=0). A second `ap_start` in RUN → no effect.
- `rst_n` asserted with 3 words queued → `strm_valid`=0 and `tready`=0 immediately. State returns to IDLE.
- With the macro, `data_length`=8: a frame of 8 gives `len_err`=0. A frame of 5 (`tlast` on 5) gives `len_err`=1, which is cleared by the next `ap_start`.
